descrambler: RTL and testbench
==============================

# descrambler

- AXI-Stream descrambler for the 802.11 7-bit LFSR (x^7 + x^4 + 1).
- Receive-side counterpart of `scrambler`, placed after the demapper/decoder and before the PHY header and payload parser.
- Each frame's state is recovered from its first 7 received bits, since the SERVICE field's first 7 bits are zero at the transmitter. Alternatively, with recovery disabled, every frame is descrambled from a fixed seed.

## Interface
- `WIDTH`, 24: data bits per beat. Must be ≥ 8. Bit 0 is first in time.
- `RECOVER`, 1: 1 recovers the state from each frame's first 7 bits; 0 uses `SEED` for every frame.
- `SEED`, 7'b1011101: initial LFSR state when `RECOVER`=0, and the reset value of the state register.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `s_axis_tdata` in WIDTH: scrambled input.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tlast` in 1: last beat of frame.
- `m_axis_tdata` out WIDTH: descrambled output.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: `s_axis_tlast` delayed with its data.
- `locked` out 1: state recovered for the current frame. Held at 1 when `RECOVER`=0.

## Operation
- **LFSR step.**
  - State s[6:0]; sequence bit b = s[6]^s[3].
  - Next state s = {s[5:0], b}.
  - Output bit = input bit ^ b.
  - A beat applies WIDTH steps, unrolled combinationally, starting from the registered state.
- **FSM with `RECOVER`=1:**
  - ACQUIRE:
    - On an accepted beat, take the post-step state as {d[0],d[1],…,d[6]}, where d = `s_axis_tdata`; d[0] lands in s[6].
    - Output bits 0..6 = 0.
    - Bits 7..WIDTH-1 are descrambled by stepping from that state.
    - The state after the beat is stored.
    - Go to RUN and set `locked`.
    - If the beat has `tlast`, stay in ACQUIRE and clear `locked`.
  - RUN:
    - Descramble each accepted beat and store the post-step state.
    - An accepted beat with `tlast` goes to ACQUIRE; `locked` is cleared in the same cycle that the output register loads that beat.
- **FSM with `RECOVER`=0:**
  - A single RUN state.
  - After an accepted `tlast` beat the state reloads to `SEED`; otherwise the post-step state is stored.
- **Backpressure.** The state register and FSM advance only on an accepted input beat (`s_axis_tvalid & s_axis_tready`). A stalled beat never advances the LFSR.
- **Reset values:**
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0.
  - `locked`=`~RECOVER`.
  - state=`SEED`, FSM=ACQUIRE (RUN if `RECOVER`=0).
  - `s_axis_tready`=1 out of reset.
- **Reset mid-frame.** The held output beat is dropped. The next accepted beat is treated as a frame start.

## Timing
- Latency: 1 cycle from input acceptance to `m_axis_tvalid`.
- Single output register. `s_axis_tready = ~m_axis_tvalid | m_axis_tready`, so full throughput of 1 beat/cycle is sustained with `m_axis_tready` high.
- `m_axis_tdata` and `m_axis_tlast` are stable while `m_axis_tvalid & ~m_axis_tready`.
- Simultaneous output drain and new input in one cycle: the register reloads with no bubble.
- `m_axis_tvalid` clears only when the register is drained and no new beat is accepted.
- `s_axis_tready` is combinational from `m_axis_tready`. This is a documented single-stage path; a downstream slice is added if timing requires it.
- A one-beat frame (`tlast` on the first beat) is legal: acquire plus descramble in the same beat, then ACQUIRE again.

## Structure
- `scrambler_defs.vh`, shared with `scrambler`:
  - polynomial tap indices (6, 3);
  - state width 7;
  - default seed 7'b1011101;
  - function `lfsr_step_word(state, data, width)` returning {next_state, out_data}.
- Sub-module `scrambler_lfsr`: combinational WIDTH-step unroller with inputs state and data, outputs next_state and out_data. `scrambler` is refactored to use it as well.
- `descrambler` holds the FSM, the state register, the output register, the handshake and `locked`.

## Test plan
- **Sequence lock.** WIDTH=24, `RECOVER`=1. Send 3 beats of `scrambler` output (SEED 7'b1011101, all-zero data, `tlast` on beat 2).
  - Beat 0 has `tdata[6:0]`=7'h36.
  - All outputs are 24'h000000.
  - `locked` rises with beat 0 and falls with beat 2.
- **Data round-trip.** Frame from `scrambler` with `data_before_scrambling.txt` (first 7 bits forced 0) → output equals the plaintext beat-for-beat. `m_axis_tlast` appears only on the final beat.
- **Back-to-back frames with different seeds.** 7'b1011101, then 7'b0000001, with no idle cycle between frames → both frames decode correctly. ACQUIRE is entered on the beat after `tlast`.
- **Backpressure.** Random `m_axis_tready` at 50% duty and random `s_axis_tvalid` gaps → output identical to the unstalled run. Data is held stable while stalled. No beat is lost or duplicated.
- **Fixed seed.** `RECOVER`=0, `SEED`=7'b1011101. Feed the `scrambler` sequence outputs (zero input) → all-zero output, with `locked` constantly 1. After `tlast` the state reloads and a second frame also decodes to zero.
- **Reset mid-frame.** Assert `aresetn`=0 for 1 cycle during beat 1 of 3 → `m_axis_tvalid`=0 immediately. A new frame sent next decodes correctly from ACQUIRE.

Source files
------------

// File: rtl/descrambler_pkg.sv
// ---------------------------------------------------------------------------
// descrambler_pkg : shared 802.11 LFSR constants, FSM encoding, step helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package descrambler_pkg;

  localparam int LFSR_W = 7;
  localparam int TAP_HI = 6;
  localparam int TAP_LO = 3;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'b1011101;

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_RUN     = 1'b1
  } desc_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/scrambler_lfsr.sv
// ---------------------------------------------------------------------------
// scrambler_lfsr : combinational WIDTH-step x^7+x^4+1 unroller (bit 0 first)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scrambler_lfsr
  import descrambler_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic [LFSR_W-1:0] state_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic [LFSR_W-1:0] next_state_o,
  output logic [WIDTH-1:0]  out_data_o
);

  logic [LFSR_W-1:0] s;
  logic [WIDTH-1:0]  d;

  always_comb begin
    s = state_i;
    d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      d[i] = data_i[i] ^ s[TAP_HI] ^ s[TAP_LO];
      s    = lfsr_next(s);
    end
    next_state_o = s;
    out_data_o   = d;
  end

endmodule

`default_nettype wire

// File: rtl/descrambler.sv
// ---------------------------------------------------------------------------
// descrambler : AXI-Stream 802.11 descrambler with per-frame state recovery
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module descrambler
  import descrambler_pkg::*;
#(
  parameter int                WIDTH   = 24,
  parameter bit                RECOVER = 1'b1,
  parameter logic [LFSR_W-1:0] SEED    = DEFAULT_SEED
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             locked
);

  localparam desc_state_e FSM_RESET = RECOVER ? ST_ACQUIRE : ST_RUN;
  localparam int          ACQ_W     = WIDTH - LFSR_W;

  desc_state_e       fsm_q, fsm_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              locked_q, locked_d;

  logic              accept;
  logic [LFSR_W-1:0] run_next, acq_state, acq_next;
  logic [WIDTH-1:0]  run_out;
  logic [ACQ_W-1:0]  acq_out;

  assign s_axis_tready = ~tvalid_q | m_axis_tready;
  assign accept        = s_axis_tvalid & s_axis_tready;

  scrambler_lfsr #(.WIDTH(WIDTH)) u_run (
    .state_i      (lfsr_q),
    .data_i       (s_axis_tdata),
    .next_state_o (run_next),
    .out_data_o   (run_out)
  );

  // The first 7 received bits are the raw sequence; earliest bit is the oldest (s[6]).
  for (genvar i = 0; i < LFSR_W; i++) begin : g_acq_state
    assign acq_state[LFSR_W-1-i] = s_axis_tdata[i];
  end

  scrambler_lfsr #(.WIDTH(ACQ_W)) u_acq (
    .state_i      (acq_state),
    .data_i       (s_axis_tdata[WIDTH-1:LFSR_W]),
    .next_state_o (acq_next),
    .out_data_o   (acq_out)
  );

  always_comb begin
    fsm_d    = fsm_q;
    lfsr_d   = lfsr_q;
    locked_d = locked_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (s_axis_tready) tvalid_d = s_axis_tvalid;
    if (accept) begin
      tlast_d = s_axis_tlast;
      if (RECOVER && (fsm_q == ST_ACQUIRE)) begin
        tdata_d = {acq_out, {LFSR_W{1'b0}}};
        lfsr_d  = acq_next;
      end else begin
        tdata_d = run_out;
        lfsr_d  = run_next;
      end
      if (RECOVER) begin
        fsm_d    = s_axis_tlast ? ST_ACQUIRE : ST_RUN;
        locked_d = ~s_axis_tlast;
      end else if (s_axis_tlast) begin
        lfsr_d = SEED;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fsm_q    <= FSM_RESET;
      lfsr_q   <= SEED;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      locked_q <= ~RECOVER;
    end else begin
      fsm_q    <= fsm_d;
      lfsr_q   <= lfsr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      locked_q <= locked_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign locked        = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_descrambler.sv
// ---------------------------------------------------------------------------
// tb_descrambler : scoreboard bench, RECOVER=1 and RECOVER=0 DUTs on one bus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_descrambler;

  localparam int         W      = 24;
  localparam logic [6:0] SEED_P = 7'b1011101;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         m_tready = 1'b1;

  logic         s_tready1, m_tvalid1, m_tlast1, locked1;
  logic [W-1:0] m_tdata1;
  logic         s_tready0, m_tvalid0, m_tlast0, locked0;
  logic [W-1:0] m_tdata0;

  always #5 clk = ~clk;

  descrambler #(.WIDTH(W), .RECOVER(1'b1), .SEED(SEED_P)) u_dut_rec (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast1), .locked(locked1)
  );

  descrambler #(.WIDTH(W), .RECOVER(1'b0), .SEED(SEED_P)) u_dut_fix (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast0), .locked(locked0)
  );

  typedef struct {
    logic [W-1:0] d_rec;
    logic [W-1:0] d_fix;
    logic         last;
    logic         lock_rec;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   bp_on = 1'b0;
  bit   gaps_on = 1'b0;
  bit   held_v = 1'b0;
  logic [W-1:0] held_d;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scrambler sequence bits [offset, offset+W) of a frame started from seed.
  function automatic logic [W-1:0] keystream(input logic [6:0] seed, input int offset);
    logic [6:0]   s  = seed;
    logic [W-1:0] ks = '0;
    logic         b;
    for (int k = 0; k < offset + W; k++) begin
      b = s[6] ^ s[3];
      if (k >= offset) ks[k-offset] = b;
      s = {s[5:0], b};
    end
    return ks;
  endfunction

  task automatic drive_beat(input logic [W-1:0] d, input logic last);
    int t = 0;
    if (gaps_on) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready1) break;
      t++;
      if (t > 1000) begin
        $display("FAIL accept_timeout: s_axis_tready stuck at %0b", s_tready1);
        $fatal(1, "input handshake never completed");
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_beat(input logic [6:0] seed, input int b, input int nbeats, input bit zero);
    exp_t         e;
    logic [W-1:0] plain, scr;
    plain = zero ? '0 : W'($urandom);
    if (b == 0) plain[6:0] = '0;
    scr        = plain ^ keystream(seed, b * W);
    e.d_rec    = plain;
    e.d_fix    = scr ^ keystream(SEED_P, b * W);
    e.last     = (b == nbeats - 1);
    e.lock_rec = ~e.last;
    exp_q.push_back(e);
    drive_beat(scr, e.last);
  endtask

  task automatic send_frame(input logic [6:0] seed, input int nbeats, input bit zero);
    for (int b = 0; b < nbeats; b++) send_beat(seed, b, nbeats, zero);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      m_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expectation per output handshake; also checks stall hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (aresetn && m_tvalid1 && m_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %h with empty scoreboard", m_tdata1);
        end else begin
          e = exp_q.pop_front();
          chk("data_recover", m_tdata1, e.d_rec);
          chk("data_fixed", m_tdata0, e.d_fix);
          chk("valid_fixed", W'(m_tvalid0), W'(1'b1));
          chk("tlast_recover", W'(m_tlast1), W'(e.last));
          chk("tlast_fixed", W'(m_tlast0), W'(e.last));
          chk("locked_recover", W'(locked1), W'(e.lock_rec));
          chk("locked_fixed", W'(locked0), W'(1'b1));
        end
      end
      if (aresetn && m_tvalid1 && !m_tready) begin
        if (held_v) chk("stall_hold", m_tdata1, held_d);
        held_v = 1'b1;
        held_d = m_tdata1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    @(negedge clk);
    chk("reset_valid", W'(m_tvalid1), '0);
    chk("reset_data", m_tdata1, '0);
    chk("reset_last", W'(m_tlast1), '0);
    chk("reset_locked_rec", W'(locked1), '0);
    chk("reset_locked_fix", W'(locked0), W'(1'b1));
    chk("reset_ready", W'(s_tready1), W'(1'b1));
    @(posedge clk); #1;

    send_frame(SEED_P, 3, 1'b1);
    send_frame(SEED_P, 3, 1'b1);

    send_frame(SEED_P, 4, 1'b0);
    send_frame(7'b0000001, 4, 1'b0);
    send_frame(7'($urandom_range(1, 127)), 1, 1'b0);
    for (int f = 0; f < 15; f++) send_frame(7'($urandom_range(1, 127)), $urandom_range(1, 6), 1'b0);

    bp_on   = 1'b1;
    gaps_on = 1'b1;
    for (int f = 0; f < 15; f++) send_frame(7'($urandom_range(1, 127)), $urandom_range(1, 6), 1'b0);
    bp_on   = 1'b0;
    gaps_on = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin @(posedge clk); guard++; end
    #1;

    send_beat(7'b0101010, 0, 3, 1'b0);
    send_beat(7'b0101010, 1, 3, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("midreset_valid_rec", W'(m_tvalid1), '0);
    chk("midreset_valid_fix", W'(m_tvalid0), '0);
    exp_q.delete();
    @(posedge clk); #1;
    aresetn = 1'b1;
    send_frame(7'b1100110, 3, 1'b0);
    send_frame(SEED_P, 2, 1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin @(posedge clk); guard++; end
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", W'(exp_q.size()), '0);
    chk("final_valid", W'(m_tvalid1), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
